// File: rtl/sysref_pkg.sv
// rtl/sysref_pkg.sv - shared FSM encoding and error counter width for the SYSREF monitor
package sysref_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam int ERR_W = 8;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sysref_sync.sv
// rtl/sysref_sync.sv - two-flop synchronizer for the SYSREF level
module sysref_sync (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sysref_monitor.sv
// rtl/sysref_monitor.sv - SYSREF edge detect, period measurement, lock FSM and arm gate
module sysref_monitor
    import sysref_pkg::*;
#(
    parameter int PERIOD_W    = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 1,
    parameter int GATE_PULSES = 1
) (
    input  logic                master_clock,
    input  logic                resetn,
    input  logic                user_sysref,
    input  logic [PERIOD_W-1:0] expected_period,
    input  logic                arm,
    output logic                sysref_rise,
    output logic                sysref_gated,
    output logic                locked,
    output logic [1:0]          state,
    output logic [PERIOD_W-1:0] period_meas,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int GC_W = $clog2(GATE_PULSES + 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W:0]   TOL_X   = (PERIOD_W + 1)'(TOL);

    logic                w_sync;
    logic                w_rise;
    logic [PERIOD_W-1:0] w_cnt_next;
    logic [PERIOD_W-1:0] w_meas_new;
    logic [PERIOD_W:0]   w_meas_x;
    logic [PERIOD_W:0]   w_exp_x;
    logic [PERIOD_W:0]   w_diff;
    logic                w_match;
    logic                w_timeout;
    logic                w_lose;

    logic                r_sync_d;
    logic                r_rise;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period_meas;
    state_t              r_state;
    logic [MC_W-1:0]     r_match_cnt;
    logic [ERR_W-1:0]    r_err_cnt;
    logic                r_locked;
    logic                r_gate;
    logic [GC_W-1:0]     r_pass_cnt;
    logic                r_gated;

    sysref_sync u_sync (
        .i_clk    (master_clock),
        .i_resetn (resetn),
        .i_d      (user_sysref),
        .o_q      (w_sync)
    );

    assign w_rise = w_sync & ~r_sync_d;

    always_comb begin
        w_cnt_next = '0;
        if (!w_rise) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
        w_meas_new = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
        w_meas_x   = {1'b0, w_meas_new};
        w_exp_x    = {1'b0, expected_period};
        w_diff     = (w_meas_x >= w_exp_x) ? (w_meas_x - w_exp_x) : (w_exp_x - w_meas_x);
        w_match    = (w_diff <= TOL_X);
        // Missing edge is judged on the value cnt is about to take, so the
        // loss lands on the same cycle cnt first exceeds the window.
        w_timeout  = ({1'b0, w_cnt_next} > (w_exp_x + TOL_X));
        w_lose     = (r_state == ST_LOCKED) && ((w_rise && !w_match) || w_timeout);
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_sync_d      <= 1'b0;
            r_rise        <= 1'b0;
            r_cnt         <= '0;
            r_period_meas <= '0;
        end else begin
            r_sync_d <= w_sync;
            r_rise   <= w_rise;
            r_cnt    <= w_cnt_next;
            if (w_rise) begin
                r_period_meas <= w_meas_new;
            end
        end
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_locked    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOST: begin
                    if (w_rise) begin
                        r_state     <= ST_ACQUIRE;
                        r_match_cnt <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_rise) begin
                        if (!w_match) begin
                            r_match_cnt <= '0;
                        end else if (r_match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                            r_state     <= ST_LOCKED;
                            r_locked    <= 1'b1;
                            r_match_cnt <= '0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_lose) begin
                        r_state   <= ST_LOST;
                        r_locked  <= 1'b0;
                        r_err_cnt <= err_sat_inc(r_err_cnt);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // r_gate covers both the armed-pending and passing phases; it can only
    // be set while locked, and loss of lock drops it in the same cycle.
    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_gate     <= 1'b0;
            r_pass_cnt <= '0;
            r_gated    <= 1'b0;
        end else begin
            r_gated <= 1'b0;
            if (w_lose) begin
                r_gate     <= 1'b0;
                r_pass_cnt <= '0;
            end else if (r_gate) begin
                if (w_rise) begin
                    r_gated <= 1'b1;
                    if (r_pass_cnt == GC_W'(GATE_PULSES - 1)) begin
                        r_gate     <= 1'b0;
                        r_pass_cnt <= '0;
                    end else begin
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                    end
                end
            end else if (arm && r_locked) begin
                r_gate <= 1'b1;
            end
        end
    end

    assign sysref_rise  = r_rise;
    assign sysref_gated = r_gated;
    assign locked       = r_locked;
    assign state        = r_state;
    assign period_meas  = r_period_meas;
    assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_sysref_monitor.sv
// tb/tb_sysref_monitor.sv - directed table-driven bench for sysref_monitor
module tb_sysref_monitor;

    localparam logic [15:0] EXP = 16'd64;
    localparam int          TOL = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        user_sysref = 1'b0;
    logic        arm = 1'b0;
    logic [15:0] expected_period = EXP;
    logic        sysref_rise;
    logic        sysref_gated;
    logic        locked;
    logic [1:0]  state;
    logic [15:0] period_meas;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;

    sysref_monitor #(
        .PERIOD_W    (16),
        .LOCK_COUNT  (4),
        .TOL         (TOL),
        .GATE_PULSES (1)
    ) dut (
        .master_clock    (clk),
        .resetn          (resetn),
        .user_sysref     (user_sysref),
        .expected_period (expected_period),
        .arm             (arm),
        .sysref_rise     (sysref_rise),
        .sysref_gated    (sysref_gated),
        .locked          (locked),
        .state           (state),
        .period_meas     (period_meas),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          p;
        int          arm_edge;
        logic [1:0]  st;
        logic        lk;
        logic        chk_pm;
        logic [15:0] pm;
        logic [7:0]  err;
        logic        g;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input int p, input int ae, input logic [1:0] st, input logic lk,
                                input logic cp, input logic [15:0] pm, input logic [7:0] err,
                                input logic g);
        vec_t v;
        v.p = p; v.arm_edge = ae; v.st = st; v.lk = lk;
        v.chk_pm = cp; v.pm = pm; v.err = err; v.g = g;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One SYSREF period: level high for the first half, rise output expected on tick 3.
    task automatic apply_row(input vec_t v, input string tag);
        int n_rise;
        int n_g;
        n_rise = 0;
        n_g = 0;
        for (int c = 1; c <= v.p; c++) begin
            user_sysref = (c <= v.p / 2);
            arm = (c == v.arm_edge);
            tick();
            n_rise += int'(sysref_rise);
            n_g += int'(sysref_gated);
            if (c == 3) begin
                rise_cyc = cyc;
                chk({tag, " rise"}, int'(sysref_rise), 1);
                chk({tag, " state"}, int'(state), int'(v.st));
                chk({tag, " locked"}, int'(locked), int'(v.lk));
                if (v.chk_pm) chk({tag, " period_meas"}, int'(period_meas), int'(v.pm));
                chk({tag, " err_cnt"}, int'(err_cnt), int'(v.err));
                chk({tag, " gated"}, int'(sysref_gated), int'(v.g));
            end
        end
        arm = 1'b0;
        chk({tag, " rise_count"}, n_rise, 1);
        chk({tag, " gated_count"}, n_g, int'(v.g));
    endtask

    initial begin
        bit seen;

        tbl[0]  = mk(64, 0,  2'd1, 1'b0, 1'b0, 16'd0,  8'd0, 1'b0);
        tbl[1]  = mk(64, 0,  2'd1, 1'b0, 1'b1, 16'd64, 8'd0, 1'b0);
        tbl[2]  = mk(64, 0,  2'd1, 1'b0, 1'b1, 16'd64, 8'd0, 1'b0);
        tbl[3]  = mk(64, 0,  2'd1, 1'b0, 1'b1, 16'd64, 8'd0, 1'b0);
        tbl[4]  = mk(64, 0,  2'd2, 1'b1, 1'b1, 16'd64, 8'd0, 1'b0);
        tbl[5]  = mk(64, 10, 2'd2, 1'b1, 1'b1, 16'd64, 8'd0, 1'b0);
        tbl[6]  = mk(66, 0,  2'd2, 1'b1, 1'b1, 16'd64, 8'd0, 1'b1);
        tbl[7]  = mk(64, 0,  2'd3, 1'b0, 1'b1, 16'd66, 8'd1, 1'b0);
        tbl[8]  = mk(64, 10, 2'd1, 1'b0, 1'b1, 16'd64, 8'd1, 1'b0);
        tbl[9]  = mk(62, 0,  2'd1, 1'b0, 1'b1, 16'd64, 8'd1, 1'b0);
        tbl[10] = mk(64, 0,  2'd1, 1'b0, 1'b1, 16'd62, 8'd1, 1'b0);
        tbl[11] = mk(65, 0,  2'd1, 1'b0, 1'b1, 16'd64, 8'd1, 1'b0);
        tbl[12] = mk(63, 0,  2'd1, 1'b0, 1'b1, 16'd65, 8'd1, 1'b0);
        tbl[13] = mk(64, 0,  2'd1, 1'b0, 1'b1, 16'd63, 8'd1, 1'b0);
        tbl[14] = mk(64, 0,  2'd2, 1'b1, 1'b1, 16'd64, 8'd1, 1'b0);

        repeat (3) tick();
        chk("reset state", int'(state), 0);
        chk("reset locked", int'(locked), 0);
        chk("reset rise", int'(sysref_rise), 0);
        chk("reset gated", int'(sysref_gated), 0);
        chk("reset period_meas", int'(period_meas), 0);
        chk("reset err_cnt", int'(err_cnt), 0);
        resetn = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 15; i++) begin
            apply_row(tbl[i], $sformatf("row%0d", i));
        end

        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (state == 2'd3) seen = 1'b1;
        end
        chk("missing edge lost", int'(seen), 1);
        chk("missing edge latency", cyc - rise_cyc, int'(EXP) + TOL + 1);
        chk("missing edge period_meas", int'(period_meas), 64);
        chk("missing edge err_cnt", int'(err_cnt), 2);
        chk("missing edge locked", int'(locked), 0);

        apply_row(mk(64, 0, 2'd1, 1'b0, 1'b0, 16'd0,  8'd2, 1'b0), "reacq1");
        apply_row(mk(64, 0, 2'd1, 1'b0, 1'b1, 16'd64, 8'd2, 1'b0), "reacq2");
        apply_row(mk(64, 0, 2'd1, 1'b0, 1'b1, 16'd64, 8'd2, 1'b0), "reacq3");
        apply_row(mk(64, 0, 2'd1, 1'b0, 1'b1, 16'd64, 8'd2, 1'b0), "reacq4");
        apply_row(mk(64, 0, 2'd2, 1'b1, 1'b1, 16'd64, 8'd2, 1'b0), "reacq5");
        apply_row(mk(64, 3, 2'd2, 1'b1, 1'b1, 16'd64, 8'd2, 1'b0), "arm_same_cycle");
        apply_row(mk(64, 0, 2'd2, 1'b1, 1'b1, 16'd64, 8'd2, 1'b1), "gate_pass");
        apply_row(mk(64, 0, 2'd2, 1'b1, 1'b1, 16'd64, 8'd2, 1'b0), "gate_closed");

        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset state", int'(state), 0);
        chk("async reset locked", int'(locked), 0);
        chk("async reset err_cnt", int'(err_cnt), 0);
        chk("async reset period_meas", int'(period_meas), 0);
        chk("async reset rise", int'(sysref_rise), 0);
        chk("async reset gated", int'(sysref_gated), 0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (3) tick();
        apply_row(mk(64, 0, 2'd1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0), "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
